// File: rtl/porta_saida_buffer_pkg.sv
// Shared constants for the memory-mapped output port: default bus addresses
// and the bit layout of the readable status byte.
package pkg_porta_saida;

  localparam logic [7:0] ENDERECO_DADOS_PADRAO  = 8'hE0;
  localparam logic [7:0] ENDERECO_STATUS_PADRAO = 8'hE1;

  localparam int BIT_CHEIO    = 7;
  localparam int BIT_VAZIO    = 6;
  localparam int BIT_OVERFLOW = 5;
  localparam int CONTAGEM_MSB = 3;

endpackage

// File: rtl/porta_saida_buffer_fifo.sv
// Synchronous first-word fall-through FIFO; a push on a full FIFO is accepted
// when a pop happens in the same cycle.
module fifo_sincrona
  import pkg_porta_saida::*;
#(
  parameter int PROFUNDIDADE = 8,
  parameter int LARGURA      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [LARGURA-1:0]    din,
  output logic [LARGURA-1:0]    dout,
  output logic                  cheio,
  output logic                  vazio,
  output logic [CONTAGEM_MSB:0] contagem
);

  localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam logic [CONTAGEM_MSB:0] CONTAGEM_CHEIA = PROFUNDIDADE[CONTAGEM_MSB:0];

  logic [LARGURA-1:0] mem [PROFUNDIDADE];
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign cheio   = (contagem == CONTAGEM_CHEIA);
  assign vazio   = (contagem == '0);
  assign pop_ok  = pop && !vazio;
  assign push_ok = push && (!cheio || pop_ok);

  // Depth is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      contagem <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   contagem <= contagem + 1'b1;
        2'b01:   contagem <= contagem - 1'b1;
        default: contagem <= contagem;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout = vazio ? '0 : mem[rd_ptr];

endmodule

// File: rtl/porta_saida_buffer.sv
// Output port on the data-memory bus: latches stores to the data address,
// queues them for a valid/ready consumer and exposes a pollable status byte.
module porta_saida_buffer
  import pkg_porta_saida::*;
#(
  parameter int         PROFUNDIDADE    = 8,
  parameter logic [7:0] ENDERECO_DADOS  = ENDERECO_DADOS_PADRAO,
  parameter logic [7:0] ENDERECO_STATUS = ENDERECO_STATUS_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] endereco,
  input  logic [7:0] dado_in,
  input  logic       write,
  output logic [7:0] dado_out,
  output logic       leitura_sel,
  output logic [7:0] leitura_dado,
  output logic       saida_valid,
  output logic [7:0] saida_dado,
  input  logic       saida_ready,
  output logic       overflow
);

  function automatic logic [7:0] monta_status(input logic cheio_f, input logic vazio_f,
                                              input logic ovf_f,
                                              input logic [CONTAGEM_MSB:0] cnt_f);
    logic [7:0] s;
    s                 = '0;
    s[BIT_CHEIO]      = cheio_f;
    s[BIT_VAZIO]      = vazio_f;
    s[BIT_OVERFLOW]   = ovf_f;
    s[CONTAGEM_MSB:0] = cnt_f;
    return s;
  endfunction

  logic                  grava_dados;
  logic                  grava_status;
  logic                  pop;
  logic                  descarta;
  logic                  cheio;
  logic                  vazio;
  logic [CONTAGEM_MSB:0] contagem;

  assign grava_dados  = write && (endereco == ENDERECO_DADOS);
  assign grava_status = write && (endereco == ENDERECO_STATUS);
  assign pop          = saida_valid && saida_ready;
  // A store is lost only when full and nothing leaves in the same cycle.
  assign descarta     = grava_dados && cheio && !pop;

  fifo_sincrona #(
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA      (8)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (grava_dados),
    .pop      (pop),
    .din      (dado_in),
    .dout     (saida_dado),
    .cheio    (cheio),
    .vazio    (vazio),
    .contagem (contagem)
  );

  assign saida_valid = !vazio;

  always_ff @(posedge clock) begin
    if (reset) begin
      dado_out <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (grava_dados) dado_out <= dado_in;
      if (descarta) overflow <= 1'b1;
      else if (grava_status && dado_in[0]) overflow <= 1'b0;
    end
  end

  assign leitura_sel  = (endereco == ENDERECO_STATUS);
  assign leitura_dado = leitura_sel ? monta_status(cheio, vazio, overflow, contagem) : 8'h00;

endmodule
